// File: rtl/ram_row_master_pkg.sv
// rtl/ram_row_master_pkg.sv - shared encodings for the row RAM master and training core
package ram_row_master_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_SCAN  = 2'd2,
    OP_RSVD  = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_TURN,
    ST_RSP
  } state_e;

  function automatic logic is_read_state(input state_e s);
    return (s == ST_RD_ADDR) || (s == ST_RD_WAIT) || (s == ST_RD_CAP);
  endfunction

  function automatic logic is_strobe_state(input state_e s);
    return (s == ST_WR_STROBE) || (s == ST_WR_HOLD);
  endfunction

  function automatic logic is_write_state(input state_e s);
    return (s == ST_WR_SETUP) || (s == ST_WR_STROBE) || (s == ST_WR_HOLD) || (s == ST_TURN);
  endfunction

endpackage

// File: rtl/ram_row_master_bus_driver.sv
// rtl/ram_row_master_bus_driver.sv - registered RAM strobes and tri-state row bus
module ram_bus_driver #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 144
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  acc_en,
  input  logic [ADDR_WIDTH-1:0] acc_addr,
  input  logic                  acc_we,
  input  logic                  acc_oe,
  input  logic [DATA_WIDTH-1:0] acc_wdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic                  ram_we_q, ram_we_d;
  logic                  ram_oe_q, ram_oe_d;

  // Next pin values; a write request always wins so the RAM never sees both strobes.
  always_comb begin
    ram_we_d   = acc_we;
    ram_oe_d   = acc_oe & ~acc_we;
    ram_addr_d = acc_en ? acc_addr : ram_addr_q;
  end

  // Pin registers; the async reset drops the write strobe and releases the bus at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ram_addr_q <= '0;
      ram_we_q   <= 1'b0;
      ram_oe_q   <= 1'b0;
    end else begin
      ram_addr_q <= ram_addr_d;
      ram_we_q   <= ram_we_d;
      ram_oe_q   <= ram_oe_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_we   = ram_we_q;
  assign ram_oe   = ram_oe_q;
  assign ram_data = ram_we_q ? acc_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: rtl/ram_row_master.sv
// rtl/ram_row_master.sv - command/response sequencer for the dataset/weight row RAM
module ram_row_master
  import ram_row_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 3,
  parameter int MAX_FEATURES   = 8,
  parameter int MAX_DATA_WIDTH = WORD_W * (MAX_FEATURES + 1),
  parameter int DEPTH          = 7,
  parameter int RD_WAIT        = 2
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [MAX_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [MAX_DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0]     rsp_addr,
  output logic                      rsp_last,
  output logic                      rsp_err,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic                      ram_we,
  output logic                      ram_oe,
  inout  wire  [MAX_DATA_WIDTH-1:0] ram_data
);

  localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [CNT_W-1:0]      CNT_LOAD   = CNT_W'(RD_WAIT - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] FIRST_ROW  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(DEPTH - 1);

  state_e                    state_q, state_d;
  cmd_op_e                   op_q, op_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [MAX_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MAX_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                      rsp_last_q, rsp_last_d;
  logic                      rsp_err_q, rsp_err_d;

  logic    accept;
  cmd_op_e cmd_op_in;
  logic    cmd_bad;
  logic    scan_more;
  logic    rsp_done;
  logic    drv_en, drv_we, drv_oe;

  assign accept    = cmd_valid && (state_q == ST_IDLE);
  assign cmd_op_in = cmd_op_e'(cmd_op);
  assign cmd_bad   = (cmd_op_in == OP_RSVD) ||
                     ((cmd_op_in != OP_SCAN) && ({1'b0, cmd_addr} >= DEPTH_X));
  assign scan_more = (op_q == OP_SCAN) && !rsp_err_q && (addr_q != LAST_ROW);
  assign rsp_done  = (state_q == ST_RSP) && rsp_ready;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: read and write sequences, scan loops back through RD_ADDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad)                     state_d = ST_RSP;
          else if (cmd_op_in == OP_WRITE)  state_d = ST_WR_SETUP;
          else                             state_d = ST_RD_ADDR;
        end
      end
      ST_RD_ADDR:   state_d = ST_RD_WAIT;
      ST_RD_WAIT:   if (cnt_q == '0) state_d = ST_RD_CAP;
      ST_RD_CAP:    state_d = ST_RSP;
      ST_WR_SETUP:  state_d = ST_WR_STROBE;
      ST_WR_STROBE: state_d = ST_WR_HOLD;
      ST_WR_HOLD:   state_d = ST_TURN;
      ST_TURN:      state_d = ST_RSP;
      ST_RSP: begin
        if (rsp_ready) state_d = scan_more ? ST_RD_ADDR : ST_IDLE;
      end
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshakes follow the current state, RAM controls follow the next state
  // so the registered pins line up with the state they belong to.
  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RSP);
    drv_oe    = is_read_state(state_d);
    drv_we    = is_strobe_state(state_d);
    drv_en    = is_read_state(state_d) || is_write_state(state_d);
  end

  // Datapath next values: latch the command, count read settle cycles, capture the row.
  always_comb begin
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      op_d       = cmd_op_in;
      addr_d     = (cmd_op_in == OP_SCAN) ? FIRST_ROW : cmd_addr;
      wdata_d    = cmd_wdata;
      rsp_data_d = '0;
      rsp_err_d  = cmd_bad;
      rsp_last_d = cmd_bad || (cmd_op_in != OP_SCAN) || (FIRST_ROW == LAST_ROW);
    end
    if (state_q == ST_RD_ADDR) cnt_d = CNT_LOAD;
    if ((state_q == ST_RD_WAIT) && (cnt_q != '0)) cnt_d = cnt_q - 1'b1;
    if (state_q == ST_RD_CAP) rsp_data_d = ram_data;
    if (rsp_done && scan_more) begin
      addr_d     = addr_q + 1'b1;
      rsp_data_d = '0;
      rsp_last_d = ((addr_q + 1'b1) == LAST_ROW);
    end
  end

  // Datapath registers; reset discards any pending response.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      op_q       <= OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_addr = addr_q;
  assign rsp_last = rsp_last_q;
  assign rsp_err  = rsp_err_q;

  ram_bus_driver #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (MAX_DATA_WIDTH)
  ) u_bus (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .acc_en    (drv_en),
    .acc_addr  (addr_d),
    .acc_we    (drv_we),
    .acc_oe    (drv_oe),
    .acc_wdata (wdata_q),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_data  (ram_data)
  );

endmodule

// File: tb/tb_ram_row_master.sv
// tb/tb_ram_row_master.sv - directed vector bench for ram_row_master
module tb_ram_row_master;

  localparam int AW    = 3;
  localparam int MF    = 8;
  localparam int DW    = 16 * (MF + 1);
  localparam int DEPTH = 7;
  localparam int RDW   = 2;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'd0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] rsp_addr;
  logic          rsp_last;
  logic          rsp_err;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic          ram_oe;
  wire  [DW-1:0] ram_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  ram_row_master #(
    .ADDR_WIDTH(AW), .MAX_FEATURES(MF), .MAX_DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_WAIT(RDW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_oe(ram_oe), .ram_data(ram_data)
  );

  function automatic logic [DW-1:0] make_row(input logic [15:0] base);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < MF + 1; k++) r[16*k +: 16] = base + 16'(k);
    return r;
  endfunction

  function automatic logic [DW-1:0] preload_row(input int i);
    logic [DW-1:0] r;
    if (i == 0) begin
      r = make_row(16'hC000);
    end else begin
      r = make_row(16'(i * 256));
      r[16*MF +: 16] = 16'(i);
    end
    return r;
  endfunction

  // Simple asynchronous-read RAM model; all array updates live in this one process.
  logic [DW-1:0] tb_mem [0:7];
  logic          preload_req = 1'b0;
  assign ram_data = ram_oe ? tb_mem[ram_addr] : {DW{1'bz}};

  always @(posedge CLK) begin
    if (preload_req) begin
      for (int i = 0; i < 8; i++) tb_mem[i] <= preload_row(i);
    end else if (ram_we) begin
      tb_mem[ram_addr] <= ram_data;
    end
  end

  task automatic check_v(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Bus contention and scan address-0 watchers run throughout.
  logic scan_active = 1'b0;
  logic seen_addr0  = 1'b0;
  always @(negedge CLK) begin
    if (RST_N) begin
      n_cmp++;
      if (ram_we && ram_oe) begin
        n_bad++;
        $display("FAIL bus_contention: ram_we=%0b ram_oe=%0b both high", ram_we, ram_oe);
      end
      if (scan_active && ram_oe && (ram_addr == '0)) seen_addr0 <= 1'b1;
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         output int lat, output int we_cnt, output int we_first,
                         output int oe_cnt, output logic wbus_ok);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge CLK);
    cmd_valid = 1'b0;
    lat = -1; we_cnt = 0; we_first = -1; oe_cnt = 0; wbus_ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (rsp_valid) begin
        lat = k;
        break;
      end
      if (ram_we) begin
        we_cnt++;
        if (we_first < 0) we_first = k;
        if (ram_data !== wdata) wbus_ok = 1'b0;
      end
      if (ram_oe) oe_cnt++;
      @(negedge CLK);
    end
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_lat;
    int            exp_we;
    int            exp_oe;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input logic [DW-1:0] ed, input logic err,
                         input int lat, input int we, input int oe);
    vecs[i].op = op; vecs[i].addr = addr; vecs[i].wdata = wd; vecs[i].exp_data = ed;
    vecs[i].exp_err = err; vecs[i].exp_lat = lat; vecs[i].exp_we = we; vecs[i].exp_oe = oe;
  endtask

  initial begin
    logic [DW-1:0] w0, w1, w2, w3, zero, saved_data;
    logic [AW-1:0] saved_addr;
    int lat, we_cnt, we_first, oe_cnt, w;
    logic wbus_ok, stable, leaked;

    w0   = 144'h0123456789ABCDEF0123456789ABCDEF0123;
    w1   = make_row(16'hA500);
    w2   = make_row(16'h5A00);
    w3   = make_row(16'h0F00);
    zero = '0;

    //        idx op    addr wdata exp_data     err  lat we oe
    set_vec(0,  2'd1, 3'd2, w0, zero,           1'b0, 4, 2, 0);
    set_vec(1,  2'd0, 3'd2, w3, w0,             1'b0, 4, 0, 4);
    set_vec(2,  2'd1, 3'd5, w1, zero,           1'b0, 4, 2, 0);
    set_vec(3,  2'd0, 3'd5, w3, w1,             1'b0, 4, 0, 4);
    set_vec(4,  2'd1, 3'd6, w2, zero,           1'b0, 4, 2, 0);
    set_vec(5,  2'd0, 3'd6, w3, w2,             1'b0, 4, 0, 4);
    set_vec(6,  2'd0, 3'd7, w3, zero,           1'b1, 0, 0, 0);
    set_vec(7,  2'd3, 3'd1, w3, zero,           1'b1, 0, 0, 0);
    set_vec(8,  2'd1, 3'd7, w3, zero,           1'b1, 0, 0, 0);
    set_vec(9,  2'd1, 3'd0, w3, zero,           1'b0, 4, 2, 0);
    set_vec(10, 2'd0, 3'd0, w0, w3,             1'b0, 4, 0, 4);
    set_vec(11, 2'd0, 3'd2, w1, w0,             1'b0, 4, 0, 4);
    set_vec(12, 2'd0, 3'd1, w1, preload_row(1), 1'b0, 4, 0, 4);

    // Reset values with the clock running; preload the RAM meanwhile.
    preload_req = 1'b1;
    repeat (3) @(negedge CLK);
    preload_req = 1'b0;
    check_i("reset_cmd_ready", int'(cmd_ready), 1);
    check_i("reset_rsp_valid", int'(rsp_valid), 0);
    check_v("reset_rsp_data", rsp_data, zero);
    check_i("reset_rsp_addr", int'(rsp_addr), 0);
    check_i("reset_rsp_last", int'(rsp_last), 0);
    check_i("reset_rsp_err", int'(rsp_err), 0);
    check_i("reset_ram_addr", int'(ram_addr), 0);
    check_i("reset_ram_we", int'(ram_we), 0);
    check_i("reset_ram_oe", int'(ram_oe), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Reset asserted during WR_STROBE of a write to row 3.
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 3'd3; cmd_wdata = make_row(16'h1000);
    @(negedge CLK);
    cmd_valid = 1'b0;
    @(negedge CLK);
    check_i("midwr_we_high", int'(ram_we), 1);
    #1 RST_N = 1'b0;
    #1;
    check_i("midwr_we_drop", int'(ram_we), 0);
    check_i("midwr_oe_low", int'(ram_oe), 0);
    check_i("midwr_rsp_valid", int'(rsp_valid), 0);
    check_i("midwr_cmd_ready", int'(cmd_ready), 1);
    @(negedge CLK);
    RST_N = 1'b1;
    leaked = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (rsp_valid || ram_we || !cmd_ready) leaked = 1'b1;
    end
    check_i("midwr_discarded", int'(leaked), 0);

    // Table of single commands.
    for (int i = 0; i < NV; i++) begin
      check_i($sformatf("v%0d_cmd_ready", i), int'(cmd_ready), 1);
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, we_cnt, we_first, oe_cnt, wbus_ok);
      check_i($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check_i($sformatf("v%0d_we_cycles", i), we_cnt, vecs[i].exp_we);
      check_i($sformatf("v%0d_oe_cycles", i), oe_cnt, vecs[i].exp_oe);
      check_v($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
      check_i($sformatf("v%0d_rsp_err", i), int'(rsp_err), int'(vecs[i].exp_err));
      check_i($sformatf("v%0d_rsp_last", i), int'(rsp_last), 1);
      check_i($sformatf("v%0d_rsp_addr", i), int'(rsp_addr), int'(vecs[i].addr));
      if (vecs[i].exp_we != 0) begin
        check_i($sformatf("v%0d_we_first", i), we_first, 1);
        check_i($sformatf("v%0d_wbus", i), int'(wbus_ok), 1);
      end
      check_i($sformatf("v%0d_oe_in_rsp", i), int'(ram_oe), 0);
      @(negedge CLK);
      check_i($sformatf("v%0d_rsp_dropped", i), int'(rsp_valid), 0);
    end

    // Full scan with a 10-cycle stall on row 3.
    preload_req = 1'b1;
    @(negedge CLK);
    preload_req = 1'b0;
    scan_active = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 3'd5;
    @(negedge CLK);
    cmd_valid = 1'b0;
    for (int row = 1; row < DEPTH; row++) begin
      w = -1;
      for (int k = 0; k < 20; k++) begin
        if (rsp_valid) begin
          w = k;
          break;
        end
        @(negedge CLK);
      end
      check_i($sformatf("scan%0d_gap", row), w, RDW + 2);
      check_i($sformatf("scan%0d_addr", row), int'(rsp_addr), row);
      check_v($sformatf("scan%0d_data", row), rsp_data, preload_row(row));
      check_i($sformatf("scan%0d_last", row), int'(rsp_last), (row == DEPTH - 1) ? 1 : 0);
      check_i($sformatf("scan%0d_err", row), int'(rsp_err), 0);
      if (row == 3) begin
        rsp_ready  = 1'b0;
        saved_data = rsp_data;
        saved_addr = rsp_addr;
        stable     = 1'b1;
        for (int k = 0; k < 10; k++) begin
          @(negedge CLK);
          if (rsp_data !== saved_data || rsp_addr !== saved_addr || !rsp_valid || ram_we || ram_oe)
            stable = 1'b0;
        end
        check_i("scan_stall_stable", int'(stable), 1);
        rsp_ready = 1'b1;
      end
      @(negedge CLK);
    end
    check_i("scan_end_cmd_ready", int'(cmd_ready), 1);
    check_i("scan_end_rsp_valid", int'(rsp_valid), 0);
    scan_active = 1'b0;
    check_i("scan_no_addr0", int'(seen_addr0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

endmodule
